clk_div_ctrl: RTL

Run-time controller for a programmable square-wave clock divider feeding the blink/VGA timing logic. Owns the half-period counter, starts and stops the divided output cleanly, and accepts new half-period values through a valid/ready handshake. New values are applied only on output edges, so no runt pulses are produced. Downstream logic uses the single-cycle `tick` strobe as a clock enable instead of clocking from `div_out`.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/half_cnt.sv | 51 +++++
 rtl/clk_div_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock-divider controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clk_div_pkg;

   // Controller states; the encoding is visible to debug tooling, keep it fixed.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PEND  = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   // Smallest legal half-period; an offered 0 is promoted to this.
   localparam int unsigned MIN_HALF = 1;

endpackage

// File: rtl/half_cnt.sv
// Half-period counter with clear/enable and a registered terminal count.
// Latency: tc_o reflects the counter value and half_i loaded on the same edge.
// Backpressure: none; counts whenever enabled.
//
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : force the counter to 0 on the next edge (wins over en_i)
//   en_i         : increment on the next edge
//   half_i       : half-period that will be active after the next edge
//   tc_o         : registered, high when count == half-1
module half_cnt #(
   parameter int unsigned CNT_W = 24
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] half_i,
   output logic             tc_o
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tc_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + ONE;
      end
   end

   // Terminal count is computed from next-state values so it is valid in the
   // same cycle the new count/half-period become visible. Equality only: the
   // count never runs past half-1 because the controller reloads it there.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= (cnt_d == (half_i - ONE));
      end
   end

   assign tc_o = tc_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for a square-wave divider: start/stop without runts and
// half-period updates that take effect only on output edges.
// Latency: all outputs registered; en_i to first div_out_o rise is H cycles.
// Backpressure: cfg_ready_o low while a shadowed half-period waits for an edge.
//
// Ports:
//   clk_i, rst_i           : clock, synchronous active-high reset
//   en_i                   : run request (level)
//   cfg_valid_i/cfg_half_i : offered half-period; cfg_ready_o accepts it
//   div_out_o              : divided square wave
//   tick_o                 : one-cycle strobe in the first cycle of a new level
//   running_o              : controller not idle
//   cur_half_o             : half-period currently in force
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W    = 24,
   parameter int unsigned DEF_HALF = 25_000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             cfg_valid_i,
   input  logic [CNT_W-1:0] cfg_half_i,
   output logic             cfg_ready_o,
   output logic             div_out_o,
   output logic             tick_o,
   output logic             running_o,
   output logic [CNT_W-1:0] cur_half_o
);

   state_e           state_q, state_d;
   logic             div_q, div_d;
   logic             tick_q, tick_d;
   logic [CNT_W-1:0] cur_half_q, cur_half_d;
   logic [CNT_W-1:0] shadow_q, shadow_d;
   logic             pend_q, pend_d;

   logic             cnt_clr, cnt_en, tc;
   logic             hs;
   logic [CNT_W-1:0] hv;

   half_cnt #(.CNT_W(CNT_W)) u_half_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (cnt_clr),
      .en_i   (cnt_en),
      .half_i (cur_half_d),
      .tc_o   (tc)
   );

   // Ready is simply "nothing pending", so it is derived from a register.
   assign hs = cfg_valid_i & ~pend_q;
   assign hv = (cfg_half_i == '0) ? CNT_W'(MIN_HALF) : cfg_half_i;

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         div_q      <= 1'b0;
         tick_q     <= 1'b0;
         cur_half_q <= CNT_W'(DEF_HALF);
         shadow_q   <= '0;
         pend_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         tick_q     <= tick_d;
         cur_half_q <= cur_half_d;
         shadow_q   <= shadow_d;
         pend_q     <= pend_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      tick_d     = 1'b0;
      cur_half_d = cur_half_q;
      shadow_d   = shadow_q;
      pend_d     = pend_q;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;

      if (state_q == ST_IDLE) begin
         cnt_clr = 1'b1;
         div_d   = 1'b0;
         if (hs) begin
            cur_half_d = hv;
         end
         if (en_i) begin
            state_d = ST_RUN;
         end
      end else if (!en_i && !div_q) begin
         // Stopping in the low phase cannot create a runt: stop at once and
         // flush whatever value is waiting (a handshake here implies none).
         state_d = ST_IDLE;
         cnt_clr = 1'b1;
         if (pend_q) begin
            cur_half_d = shadow_q;
         end else if (hs) begin
            cur_half_d = hv;
         end
         pend_d = 1'b0;
      end else begin
         if (tc) begin
            cnt_clr = 1'b1;
            div_d   = ~div_q;
            tick_d  = 1'b1;
            // A value arriving on the edge itself governs the new half-period.
            if (pend_q) begin
               cur_half_d = shadow_q;
            end else if (hs) begin
               cur_half_d = hv;
            end
            pend_d = 1'b0;
         end else begin
            cnt_en = 1'b1;
            if (hs) begin
               shadow_d = hv;
               pend_d   = 1'b1;
            end
         end

         // With en low we only get here in the high phase: a toggle now is
         // the falling edge that completes the drain.
         if (!en_i) begin
            state_d = tc ? ST_IDLE : ST_DRAIN;
         end else begin
            state_d = pend_d ? ST_PEND : ST_RUN;
         end
      end
   end

   // Output logic
   always_comb begin
      running_o   = (state_q != ST_IDLE);
      cfg_ready_o = ~pend_q;
      div_out_o   = div_q;
      tick_o      = tick_q;
      cur_half_o  = cur_half_q;
   end

endmodule
